// File: rtl/tlul_rr_arbiter_if.sv
// TL-UL beat types and the host/device bundle
// shared by the round-robin arbiter.
package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

interface tlul_rr_arbiter_if #(
    parameter int M      = 2,
    parameter int MaxOut = 4
);
    import tlul_pkg::*;

    localparam int CW = $clog2(MaxOut + 1);

    tl_h2d_t       tl_h_i [M];
    tl_d2h_t       tl_h_o [M];
    tl_h2d_t       tl_d_o;
    tl_d2h_t       tl_d_i;
    logic          busy_o;
    logic [CW-1:0] out_cnt_o;
    logic          err_o;

    modport slave (
        input  tl_h_i, tl_d_i,
        output tl_h_o, tl_d_o, busy_o, out_cnt_o, err_o
    );

    modport master (
        output tl_h_i, tl_d_i,
        input  tl_h_o, tl_d_o, busy_o, out_cnt_o, err_o
    );
endinterface

// File: rtl/tlul_rr_arbiter.sv
// Round-robin TL-UL arbiter: M hosts share one in-order device,
// responses routed back through an in-order ID FIFO.
module tlul_rr_arbiter #(
    parameter int M      = 2,
    parameter int MaxOut = 4
) (
    input logic              clk_i,
    input logic              rst_i,
    tlul_rr_arbiter_if.slave bus
);
    import tlul_pkg::*;

    localparam int PW = (M > 1) ? $clog2(M) : 1;
    localparam int AW = (MaxOut > 1) ? $clog2(MaxOut) : 1;
    localparam int CW = $clog2(MaxOut + 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] lock_idx_q;
    logic          lock_q;
    logic [PW-1:0] fifo_q [MaxOut];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          err_q;

    logic [PW-1:0] gnt;
    logic [PW-1:0] gnt_nxt;
    logic [PW-1:0] head;
    logic          gnt_vld;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    tl_h2d_t d_o;
    tl_d2h_t h_o [M];

    assign full  = (cnt_q == CW'(MaxOut));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_ptr];

    // A locked grant is held until its handshake; otherwise scan from ptr_q.
    always_comb begin
        int            idx;
        logic [PW-1:0] sel;
        gnt     = ptr_q;
        gnt_vld = 1'b0;
        idx     = 0;
        sel     = '0;
        if (lock_q) begin
            gnt     = lock_idx_q;
            gnt_vld = bus.tl_h_i[lock_idx_q].a_valid & ~full;
        end else begin
            for (int k = 0; k < M; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= M) idx = idx - M;
                sel = PW'(idx);
                if (!gnt_vld && !full && bus.tl_h_i[sel].a_valid) begin
                    gnt     = sel;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    assign gnt_nxt = (gnt == PW'(M - 1)) ? '0 : gnt + 1'b1;

    always_comb begin
        d_o         = bus.tl_h_i[gnt];
        d_o.a_valid = gnt_vld;
        d_o.d_ready = empty ? 1'b1 : bus.tl_h_i[head].d_ready;
    end

    always_comb begin
        for (int i = 0; i < M; i++) begin
            h_o[i]         = bus.tl_d_i;
            h_o[i].a_ready = (gnt == PW'(i)) & bus.tl_d_i.a_ready & ~full;
            h_o[i].d_valid = ~empty & (head == PW'(i)) & bus.tl_d_i.d_valid;
        end
    end

    assign push = gnt_vld & bus.tl_d_i.a_ready;
    assign pop  = ~empty & bus.tl_d_i.d_valid & d_o.d_ready;

    assign bus.tl_d_o    = d_o;
    assign bus.tl_h_o    = h_o;
    assign bus.busy_o    = ~empty;
    assign bus.out_cnt_o = cnt_q;
    assign bus.err_o     = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < MaxOut; i++) fifo_q[i] <= '0;
        end else begin
            // Dropping a_valid while stalled also releases the lock.
            lock_q     <= gnt_vld & ~bus.tl_d_i.a_ready;
            lock_idx_q <= gnt;
            if (push) begin
                fifo_q[wr_ptr] <= gnt;
                wr_ptr         <= wr_ptr + 1'b1;
                ptr_q          <= gnt_nxt;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            err_q <= empty & bus.tl_d_i.d_valid;
        end
    end
endmodule

// File: tb/tb_tlul_rr_arbiter.sv
// Directed bench for tlul_rr_arbiter with M=2, MaxOut=4:
// round-robin, lock, full FIFO, push/pop, orphan and async reset.
module tb_tlul_rr_arbiter;
    import tlul_pkg::*;

    localparam logic [31:0] H0 = 32'h1000_0000;
    localparam logic [31:0] H1 = 32'h2000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tlul_rr_arbiter_if #(.M(2), .MaxOut(4)) bus ();

    tlul_rr_arbiter #(.M(2), .MaxOut(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int h, input logic v, input logic [31:0] addr);
        bus.tl_h_i[h].a_valid   = v;
        bus.tl_h_i[h].a_address = addr;
        bus.tl_h_i[h].a_source  = 8'(h);
    endtask

    task automatic set_d(input logic v, input logic [31:0] data);
        bus.tl_d_i.d_valid = v;
        bus.tl_d_i.d_data  = data;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) bus.tl_h_i[i] = '0;
        bus.tl_d_i = '0;
        rst = 1'b1;
        #2;
        chk("rst_cnt", bus.out_cnt_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_ar0", bus.tl_h_o[0].a_ready, 0);
        chk("rst_dv1", bus.tl_h_o[1].d_valid, 0);
        chk("rst_dready", bus.tl_d_o.d_ready, 1);
        tick();
        rst = 1'b0;

        // Round-robin under continuous load
        bus.tl_h_i[0].d_ready = 1'b1;
        bus.tl_h_i[1].d_ready = 1'b1;
        bus.tl_d_i.a_ready    = 1'b1;
        set_a(0, 1, H0);
        set_a(1, 1, H1);
        #1;
        chk("rr_g0", bus.tl_d_o.a_address, H0);
        chk("rr_ar0", bus.tl_h_o[0].a_ready, 1);
        chk("rr_ar1", bus.tl_h_o[1].a_ready, 0);
        tick();
        set_a(0, 1, H0 + 4);
        set_a(1, 1, H1 + 4);
        set_d(1, 32'hD0);
        #1;
        chk("rr_g1", bus.tl_d_o.a_address, H1 + 4);
        chk("rr_dv0", bus.tl_h_o[0].d_valid, 1);
        chk("rr_dv1n", bus.tl_h_o[1].d_valid, 0);
        chk("rr_dd0", bus.tl_h_o[0].d_data, 32'hD0);
        tick();
        set_a(0, 1, H0 + 8);
        set_a(1, 1, H1 + 8);
        set_d(1, 32'hD1);
        #1;
        chk("rr_g2", bus.tl_d_o.a_address, H0 + 8);
        chk("rr_dv1", bus.tl_h_o[1].d_valid, 1);
        chk("rr_dv0n", bus.tl_h_o[0].d_valid, 0);
        chk("rr_cnt", bus.out_cnt_o, 1);
        tick();
        set_a(0, 0, 0);
        set_a(1, 0, 0);
        set_d(1, 32'hD2);
        #1;
        chk("rr_dv0b", bus.tl_h_o[0].d_valid, 1);
        chk("rr_av", bus.tl_d_o.a_valid, 0);
        tick();
        set_d(0, 0);
        #1;
        chk("rr_cnt0", bus.out_cnt_o, 0);
        chk("rr_busy0", bus.busy_o, 0);

        // One request from host 1 moves the pointer back to 0
        set_a(1, 1, H1 + 32'h10);
        #1;
        chk("solo_g1", bus.tl_d_o.a_address, H1 + 32'h10);
        tick();

        // Lock during a 3-cycle stall
        bus.tl_d_i.a_ready = 1'b0;
        set_a(1, 1, H1 + 32'h20);
        #1;
        chk("lk_g1", bus.tl_d_o.a_address, H1 + 32'h20);
        chk("lk_ar1", bus.tl_h_o[1].a_ready, 0);
        tick();
        set_a(0, 1, H0 + 32'h20);
        #1;
        chk("lk_g2", bus.tl_d_o.a_address, H1 + 32'h20);
        chk("lk_ar0", bus.tl_h_o[0].a_ready, 0);
        tick();
        #1;
        chk("lk_g3", bus.tl_d_o.a_address, H1 + 32'h20);
        tick();
        bus.tl_d_i.a_ready = 1'b1;
        #1;
        chk("lk_hs", bus.tl_d_o.a_address, H1 + 32'h20);
        chk("lk_hs_ar1", bus.tl_h_o[1].a_ready, 1);
        chk("lk_hs_ar0", bus.tl_h_o[0].a_ready, 0);
        tick();
        set_a(1, 0, 0);
        #1;
        chk("lk_next", bus.tl_d_o.a_address, H0 + 32'h20);
        chk("lk_next_ar0", bus.tl_h_o[0].a_ready, 1);
        tick();
        set_a(0, 0, 0);
        bus.tl_d_i.a_ready = 1'b0;

        // Head is host 1; host 1 back-pressures the D channel first
        bus.tl_h_i[1].d_ready = 1'b0;
        set_d(1, 32'hD3);
        #1;
        chk("bp_dready", bus.tl_d_o.d_ready, 0);
        chk("bp_dv1", bus.tl_h_o[1].d_valid, 1);
        tick();
        chk("bp_cnt", bus.out_cnt_o, 3);
        bus.tl_h_i[1].d_ready = 1'b1;
        #1;
        chk("bp_dready1", bus.tl_d_o.d_ready, 1);
        tick();

        // Simultaneous push and pop at count 2
        bus.tl_d_i.a_ready = 1'b1;
        set_a(1, 1, H1 + 32'h30);
        set_d(1, 32'hD4);
        #1;
        chk("sp_g", bus.tl_d_o.a_address, H1 + 32'h30);
        chk("sp_dv1", bus.tl_h_o[1].d_valid, 1);
        chk("sp_dv0", bus.tl_h_o[0].d_valid, 0);
        chk("sp_dd1", bus.tl_h_o[1].d_data, 32'hD4);
        tick();
        set_a(1, 0, 0);
        set_d(1, 32'hD5);
        #1;
        chk("sp_cnt", bus.out_cnt_o, 2);
        chk("sp_head0", bus.tl_h_o[0].d_valid, 1);
        chk("sp_head0n", bus.tl_h_o[1].d_valid, 0);
        tick();
        set_d(1, 32'hD6);
        #1;
        chk("sp_head1", bus.tl_h_o[1].d_valid, 1);
        tick();
        set_d(0, 0);

        // Fill the FIFO with 4 requests and no responses
        set_a(0, 1, H0 + 32'h40);
        repeat (4) tick();
        chk("full_cnt", bus.out_cnt_o, 4);
        chk("full_busy", bus.busy_o, 1);
        chk("full_ar0", bus.tl_h_o[0].a_ready, 0);
        chk("full_av", bus.tl_d_o.a_valid, 0);
        set_d(1, 32'hD7);
        #1;
        chk("full_dv0", bus.tl_h_o[0].d_valid, 1);
        chk("full_ar0b", bus.tl_h_o[0].a_ready, 0);
        tick();
        set_d(0, 0);
        #1;
        chk("full_cnt3", bus.out_cnt_o, 3);
        chk("full_ar0c", bus.tl_h_o[0].a_ready, 1);
        chk("full_av1", bus.tl_d_o.a_valid, 1);
        tick();
        chk("full_cnt4", bus.out_cnt_o, 4);
        set_a(0, 0, 0);

        // Asynchronous reset with 3 outstanding
        set_d(1, 32'hD8);
        tick();
        set_d(0, 0);
        bus.tl_d_i.a_ready = 1'b0;
        set_a(0, 1, H0 + 32'h50);
        set_a(1, 1, H1 + 32'h50);
        #1;
        chk("prerst_cnt", bus.out_cnt_o, 3);
        chk("prerst_g", bus.tl_d_o.a_address, H1 + 32'h50);
        rst = 1'b1;
        #1;
        chk("arst_cnt", bus.out_cnt_o, 0);
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_ptr", bus.tl_d_o.a_address, H0 + 32'h50);
        tick();
        rst = 1'b0;
        set_a(0, 0, 0);
        set_a(1, 0, 0);

        // Orphan response
        bus.tl_h_i[0].d_ready = 1'b0;
        bus.tl_h_i[1].d_ready = 1'b0;
        set_d(1, 32'hD9);
        #1;
        chk("orph_dready", bus.tl_d_o.d_ready, 1);
        chk("orph_dv0", bus.tl_h_o[0].d_valid, 0);
        chk("orph_dv1", bus.tl_h_o[1].d_valid, 0);
        chk("orph_err0", bus.err_o, 0);
        tick();
        set_d(0, 0);
        chk("orph_err1", bus.err_o, 1);
        tick();
        chk("orph_err2", bus.err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
